instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the program counter and issues one-outstanding-request fetches to instruction memory. Presents {instruction, PC} to the IF/ID register each cycle and inserts bubbles (all-zero instruction) on memory wait or redirect. Honours the hazard-unit stall and EX-stage branch redirects.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
BUBBLE, 32'h00000000, instruction word driven when ifValid=0; matches the IF/ID flush value

Ports:
clk  input  1  clock, rising edge
resetN  input  1  asynchronous active-low reset
dontUpdate  input  1  stall from hazard unit; the IF/ID register will not sample this cycle
branchTaken  input  1  redirect request from EX
branchTarget  input  32  redirect PC; bits [1:0] ignored and forced to 0
imemReq  output  1  fetch request valid
imemAddr  output  32  fetch address; stable while imemReq=1 and imemReady=0
imemReady  input  1  response valid this cycle; may be combinational from imemReq
imemRdata  input  32  instruction word, valid when imemReady=1
ifInstruction  output  32  to IF/ID register
ifProgramCounter  output  32  to IF/ID register
ifValid  output  1  1 = real instruction, 0 = bubble

Behaviour:
- State: pc[31:0], holdInstr[31:0], holdPc[31:0], discardAddr[31:0], and FSM {REQ, HOLD, DISCARD}.
- Reset (resetN=0, asynchronous): state=REQ, pc=RESET_PC, holdInstr/holdPc/discardAddr=0. While reset is asserted: imemReq=0, ifValid=0, ifInstruction=BUBBLE, ifProgramCounter=0. The first request issues in the first cycle after release.
- Outputs are combinational from state and registers. There is zero added latency from imemReady to ifInstruction.
- REQ: imemReq=1, imemAddr=pc.
  - imemReady=0: ifValid=0, ifInstruction=BUBBLE, ifProgramCounter=pc. Stay in REQ.
  - imemReady=1: ifValid=1, ifInstruction=imemRdata, ifProgramCounter=pc.
    - dontUpdate=0: pc<=pc+4, stay in REQ.
    - dontUpdate=1: holdInstr<=imemRdata, holdPc<=pc, go to HOLD.
- HOLD: imemReq=0, ifValid=1, outputs = holdInstr/holdPc. When dontUpdate=0: pc<=holdPc+4, go to REQ. Otherwise stay in HOLD.
- DISCARD: imemReq=1, imemAddr=discardAddr, ifValid=0, ifInstruction=BUBBLE. On imemReady=1 the data is dropped and the state goes to REQ (fetching the new pc).
- branchTaken=1 has highest priority, overrides dontUpdate, and applies in any state:
  - Outputs for the cycle: ifValid=0, ifInstruction=BUBBLE.
  - pc<={branchTarget[31:2],2'b00}.
  - If state=REQ and imemReady=0, the request cannot be withdrawn: discardAddr<=pc, go to DISCARD.
  - If state=DISCARD and imemReady=0: stay in DISCARD with discardAddr unchanged.
  - Otherwise: go to REQ. Any hold contents are lost.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
- At most one outstanding request. imemAddr never changes while imemReq=1 and imemReady=0.
- Reset asserted mid-request abandons the request. Memory must tolerate a dropped imemReq.

Test Plan:
- Reset, RESET_PC=0, imemReady tied 1, imemRdata=pc-derived pattern, no stall -> imemAddr sequence 0,4,8,C on consecutive cycles; ifValid=1 every cycle with matching ifProgramCounter.
- imemReady low for 2 cycles at addr 8 -> imemAddr held at 8; ifValid=0 and ifInstruction=0 for 2 cycles; then ifInstruction=mem[8], ifProgramCounter=8, next imemAddr=C.
- Response at addr 4 with dontUpdate=1 for 3 cycles -> HOLD: imemReq=0, ifInstruction=mem[4], ifProgramCounter=4 held all 3 cycles; after release next imemAddr=8.
- branchTaken=1, branchTarget=32'h00000103 while addr 0x10 is pending (imemReady=0) -> ifValid=0; imemAddr stays 0x10 until ready, response discarded; next imemAddr=0x100; no mem[0x10] ever reaches ifValid=1.
- branchTaken together with dontUpdate=1 in HOLD -> hold dropped; next cycle imemAddr=branchTarget, state REQ.
- pc=32'hFFFFFFFC, ready=1, no stall -> next imemAddr=0. Assert resetN low mid-wait -> imemReq=0 immediately (asynchronous); after release imemAddr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// instruction_fetch_unit : PC owner and single-outstanding fetch stage feeding IF/ID
// Revision 1.0
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        dontUpdate,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRdata,
  output logic [31:0] ifInstruction,
  output logic [31:0] ifProgramCounter,
  output logic        ifValid
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  r_state,        w_state_next;
  logic [31:0] r_pc,           w_pc_next;
  logic [31:0] r_hold_instr,   w_hold_instr_next;
  logic [31:0] r_hold_pc,      w_hold_pc_next;
  logic [31:0] r_discard_addr, w_discard_addr_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= S_REQ;
      r_pc           <= RESET_PC;
      r_hold_instr   <= 32'h0;
      r_hold_pc      <= 32'h0;
      r_discard_addr <= 32'h0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_hold_instr   <= w_hold_instr_next;
      r_hold_pc      <= w_hold_pc_next;
      r_discard_addr <= w_discard_addr_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_hold_instr_next   = r_hold_instr;
    w_hold_pc_next      = r_hold_pc;
    w_discard_addr_next = r_discard_addr;
    if (branchTaken) begin
      w_pc_next = {branchTarget[31:2], 2'b00};
      // An unanswered request cannot be withdrawn; its response must be swallowed.
      if (r_state == S_REQ && !imemReady) begin
        w_discard_addr_next = r_pc;
        w_state_next        = S_DISCARD;
      end else if (r_state == S_DISCARD && !imemReady) begin
        w_state_next = S_DISCARD;
      end else begin
        w_state_next = S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (imemReady) begin
            if (!dontUpdate) begin
              w_pc_next = r_pc + 32'd4;
            end else begin
              w_hold_instr_next = imemRdata;
              w_hold_pc_next    = r_pc;
              w_state_next      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!dontUpdate) begin
            w_pc_next    = r_hold_pc + 32'd4;
            w_state_next = S_REQ;
          end
        end
        S_DISCARD: begin
          if (imemReady) w_state_next = S_REQ;
        end
        default: w_state_next = S_REQ;
      endcase
    end
  end

  always_comb begin
    imemReq          = 1'b0;
    imemAddr         = r_pc;
    ifValid          = 1'b0;
    ifInstruction    = BUBBLE;
    ifProgramCounter = r_pc;
    case (r_state)
      S_REQ: begin
        imemReq = 1'b1;
        if (imemReady) begin
          ifValid       = 1'b1;
          ifInstruction = imemRdata;
        end
      end
      S_HOLD: begin
        ifValid          = 1'b1;
        ifInstruction    = r_hold_instr;
        ifProgramCounter = r_hold_pc;
      end
      S_DISCARD: begin
        imemReq  = 1'b1;
        imemAddr = r_discard_addr;
      end
      default: ;
    endcase
    if (branchTaken) begin
      ifValid       = 1'b0;
      ifInstruction = BUBBLE;
    end
    // Reset drops the request immediately, independent of the clock.
    if (!resetN) begin
      imemReq          = 1'b0;
      ifValid          = 1'b0;
      ifInstruction    = BUBBLE;
      ifProgramCounter = 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// tb_instruction_fetch_unit : randomized fetch traffic checked against a transaction-level model
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        dontUpdate;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] ifInstruction;
  logic [31:0] ifProgramCounter;
  logic        ifValid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imemRdata = mem_word(imemAddr);

  instruction_fetch_unit #(.RESET_PC(32'h0), .BUBBLE(32'h0)) dut (
    .clk(clk), .resetN(resetN), .dontUpdate(dontUpdate), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemReady(imemReady), .imemRdata(imemRdata), .ifInstruction(ifInstruction),
    .ifProgramCounter(ifProgramCounter), .ifValid(ifValid)
  );

  // Reference: next PC, an optional held instruction, an optional orphaned request.
  logic [31:0] m_pc, m_hpc, m_hinstr, m_daddr;
  bit          m_held, m_disc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_held = 0; m_disc = 0; m_hpc = 0; m_hinstr = 0; m_daddr = 0;
  endtask

  // Entered at posedge+1; applies one cycle of inputs, checks, advances the model.
  task automatic step(input bit stall, input bit br, input logic [31:0] tgt, input bit rdy);
    bit          e_req, e_valid;
    logic [31:0] e_addr, e_instr, e_pc;
    dontUpdate = stall; branchTaken = br; branchTarget = tgt; imemReady = rdy;
    #1;
    if (m_held) begin
      e_req = 0; e_valid = !br; e_instr = br ? 32'h0 : m_hinstr; e_pc = m_hpc; e_addr = 0;
    end else if (m_disc) begin
      e_req = 1; e_addr = m_daddr; e_valid = 0; e_instr = 0; e_pc = 0;
    end else begin
      e_req = 1; e_addr = m_pc; e_valid = rdy && !br;
      e_instr = e_valid ? mem_word(m_pc) : 32'h0; e_pc = m_pc;
    end
    chk("imemReq", {31'h0, imemReq}, {31'h0, e_req});
    if (e_req) chk("imemAddr", imemAddr, e_addr);
    chk("ifValid", {31'h0, ifValid}, {31'h0, e_valid});
    chk("ifInstruction", ifInstruction, e_instr);
    if (!m_disc) chk("ifProgramCounter", ifProgramCounter, e_pc);
    if (br) begin
      if (e_req && !rdy) begin
        m_daddr = e_addr; m_disc = 1;
      end else begin
        m_disc = 0;
      end
      m_held = 0;
      m_pc   = {tgt[31:2], 2'b00};
    end else if (m_held) begin
      if (!stall) begin m_held = 0; m_pc = m_hpc + 32'd4; end
    end else if (m_disc) begin
      if (rdy) m_disc = 0;
    end else if (rdy) begin
      if (stall) begin m_held = 1; m_hpc = m_pc; m_hinstr = mem_word(m_pc); end
      else m_pc = m_pc + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    resetN = 1'b0; dontUpdate = 0; branchTaken = 0; branchTarget = 0; imemReady = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'h0, imemReq}, 32'h0);
    chk("rst_valid", {31'h0, ifValid}, 32'h0);
    chk("rst_instr", ifInstruction, 32'h0);
    chk("rst_pc",    ifProgramCounter, 32'h0);
    resetN = 1'b1;

    // Sequential streaming, then a two-cycle wait at address 8
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    // Stall three cycles on a returned word, then release
    step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1); step(0, 0, 0, 1);
    // Branch while a request is pending; response is discarded
    step(0, 1, 32'h0000_0103, 0); step(0, 0, 0, 0); step(0, 0, 0, 1);
    chk("redirect_addr", imemAddr, 32'h0000_0100);
    step(0, 0, 0, 1);
    // Branch while holding, with the stall still asserted
    step(1, 0, 0, 1); step(1, 1, 32'h0000_0200, 1); step(0, 0, 0, 1);
    // PC wrap-around
    step(0, 1, 32'hFFFF_FFFF, 1); step(0, 0, 0, 1);
    chk("wrap_addr", imemAddr, 32'h0000_0000);
    step(0, 0, 0, 1);

    for (int i = 0; i < 800; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, t, $urandom_range(0, 9) < 6);
    end

    // Asynchronous reset in the middle of a wait
    step(0, 0, 0, 0);
    imemReady = 0; dontUpdate = 0; branchTaken = 0;
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_req",   {31'h0, imemReq}, 32'h0);
    chk("async_rst_valid", {31'h0, ifValid}, 32'h0);
    @(posedge clk); #1;
    resetN = 1'b1;
    model_reset();
    imemReady = 1;
    #1 chk("post_rst_addr", imemAddr, 32'h0);
    #1;  // still inside the same cycle; step continues from here
    step(0, 0, 0, 1); step(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
